// File: rtl/tx_symbol_sched_pkg.sv
// Shared types and defaults for the TX symbol scheduler slice.
// The CP length selector is shared so every user picks the same CP for a given lcp flag.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    CP,
    BODY
  } state_t;

  localparam int unsigned FFT_SIZE_DEF = 2048;
  localparam int unsigned CP_LEN1_DEF  = 176;
  localparam int unsigned CP_LEN2_DEF  = 144;

  function automatic int unsigned cp_sel(input logic lcp,
                                         input int unsigned cp_len1,
                                         input int unsigned cp_len2);
    return lcp ? cp_len1 : cp_len2;
  endfunction

endpackage

// File: rtl/tx_symbol_sched_if.sv
// Channel handshake and sample-stream strobes between the scheduler and the per-antenna buffers.
interface tx_symbol_sched_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_grant;
  logic [NUM_CH-1:0] ch_rd_en;
  logic              out_valid;
  logic              out_cp;
  logic              out_sop;
  logic              out_eop;
  logic [2:0]        out_ch;

  modport master (
    input  ch_mask, ch_ready,
    output ch_grant, ch_rd_en, out_valid, out_cp, out_sop, out_eop, out_ch
  );

  modport slave (
    output ch_mask, ch_ready,
    input  ch_grant, ch_rd_en, out_valid, out_cp, out_sop, out_eop, out_ch
  );
endinterface

// File: rtl/tx_symbol_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [2:0]        idx,
  output logic              found
);

  always_comb begin : search
    int j;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = (int'(ptr) + i) % NUM_CH;
      if (!found && eligible[j]) begin
        grant[j] = 1'b1;
        idx      = 3'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_symbol_sched.sv
// Shares one CP-insert/packer datapath between NUM_CH requesters, one symbol burst per tx_trigger,
// with a one-deep trigger backlog and underrun/overrun reporting.
module tx_symbol_sched
  import tx_sched_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int FFT_SIZE = FFT_SIZE_DEF,
  parameter int CP_LEN1  = CP_LEN1_DEF,
  parameter int CP_LEN2  = CP_LEN2_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_tx,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 tx_trigger,
  input  logic                 tx_lcp,
  tx_symbol_sched_if.master    bus,
  output logic                 underrun,
  output logic                 overrun,
  output logic [CNT_W-1:0]     underrun_cnt,
  output logic [CNT_W-1:0]     overrun_cnt,
  output logic                 busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state_q, state_d;
  logic                pend_q, pend_d, pend_lcp_q, pend_lcp_d;
  logic [CNT_W-1:0]    cp_len_q, cp_len_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [2:0]          ch_q, ch_d;
  logic                valid_q, valid_d, cp_q, cp_d, sop_q, sop_d, eop_q, eop_d;
  logic [CNT_W-1:0]    un_cnt_q, ov_cnt_q;
  logic [NUM_CH-1:0]   arb_grant;
  logic [2:0]          arb_idx;
  logic                arb_found;
  logic                trig, last, consume;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .eligible (bus.ch_mask & bus.ch_ready),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .found    (arb_found)
  );

  assign trig    = enable & tx_trigger;
  assign last    = (cnt_q == '0);
  // The backlog is consumed when a new burst starts from it, either out of IDLE or straight after eop.
  assign consume = pend_q && ((state_q == IDLE) || (state_q == BODY && last));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_lcp_d = pend_lcp_q;
    cp_len_d   = cp_len_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ch_d       = ch_q;
    underrun   = 1'b0;
    overrun    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      if (consume) begin
        pend_d = trig;
        if (trig) pend_lcp_d = tx_lcp;
      end else if (trig && state_q != IDLE) begin
        if (pend_q) begin
          overrun = 1'b1;
        end else begin
          pend_d     = 1'b1;
          pend_lcp_d = tx_lcp;
        end
      end

      case (state_q)
        IDLE: if (pend_q || trig) begin
          state_d  = ARB;
          cp_len_d = CNT_W'(cp_sel(pend_q ? pend_lcp_q : tx_lcp, CP_LEN1, CP_LEN2));
        end
        ARB: if (!arb_found) begin
          underrun = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = CP;
          cnt_d   = cp_len_q - CNT_W'(1);
          grant_d = arb_grant;
          ch_d    = arb_idx;
          ptr_d   = (int'(arb_idx) == NUM_CH - 1) ? '0 : PTR_W'(arb_idx + 3'd1);
        end
        CP: if (last) begin
          state_d = BODY;
          cnt_d   = CNT_W'(FFT_SIZE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        BODY: if (last) begin
          if (pend_q) begin
            state_d  = ARB;
            cp_len_d = CNT_W'(cp_sel(pend_lcp_q, CP_LEN1, CP_LEN2));
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d == CP) || (state_d == BODY);
    cp_d    = (state_d == CP);
    sop_d   = (state_q == ARB) && (state_d == CP);
    eop_d   = (state_d == BODY) && (cnt_d == '0);
    if (!valid_d) begin
      grant_d = '0;
      ch_d    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_lcp_q <= 1'b0;
      cp_len_q   <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      cp_q       <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      un_cnt_q   <= '0;
      ov_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_lcp_q <= pend_lcp_d;
      cp_len_q   <= cp_len_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
      cp_q       <= cp_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      if (underrun && un_cnt_q != '1) un_cnt_q <= un_cnt_q + CNT_W'(1);
      if (overrun && ov_cnt_q != '1)  ov_cnt_q <= ov_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ch_grant  = grant_q;
  assign bus.ch_rd_en  = valid_q ? grant_q : '0;
  assign bus.out_valid = valid_q;
  assign bus.out_cp    = cp_q;
  assign bus.out_sop   = sop_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_ch    = ch_q;
  assign underrun_cnt  = un_cnt_q;
  assign overrun_cnt   = ov_cnt_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_tx_symbol_sched.sv
// Directed bench for tx_symbol_sched with FFT_SIZE=16, CP_LEN1=4, CP_LEN2=2, NUM_CH=2.
module tb_tx_symbol_sched;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic clk_tx = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, tx_trigger = 1'b0, tx_lcp = 1'b0;
  logic underrun, overrun, busy;
  logic [CNT_W-1:0] underrun_cnt, overrun_cnt;

  tx_symbol_sched_if #(.NUM_CH(NUM_CH)) bus ();

  tx_symbol_sched #(
    .NUM_CH(NUM_CH), .FFT_SIZE(16), .CP_LEN1(4), .CP_LEN2(2), .CNT_W(CNT_W)
  ) dut (
    .clk_tx       (clk_tx),
    .rst_n        (rst_n),
    .enable       (enable),
    .tx_trigger   (tx_trigger),
    .tx_lcp       (tx_lcp),
    .bus          (bus),
    .underrun     (underrun),
    .overrun      (overrun),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt),
    .busy         (busy)
  );

  always #5 clk_tx = ~clk_tx;

  int n_checks = 0, n_err = 0;
  int cyc, valid_n, cp_n, rd_n, sop_n, eop_n, ov_n, un_n, ov_cyc, un_cyc, eop_cyc, bad_rd, grant_chg;
  logic [1:0]  sop_grant[$];
  logic [2:0]  sop_ch[$];
  int          sop_cyc[$];
  logic        busy_h[0:127];
  logic [13:0] outs_h[0:127];
  logic [1:0]  cur_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; valid_n = 0; cp_n = 0; rd_n = 0; sop_n = 0; eop_n = 0;
    ov_n = 0; un_n = 0; ov_cyc = -1; un_cyc = -1; eop_cyc = -1; bad_rd = 0; grant_chg = 0;
    cur_grant = '0;
    sop_grant.delete(); sop_ch.delete(); sop_cyc.delete();
    for (int i = 0; i < 128; i++) begin
      busy_h[i] = 1'b0;
      outs_h[i] = '0;
    end
  endtask

  // Samples the current cycle 1 ns after inputs are driven, then advances one clock.
  task automatic tick();
    #1;
    if (cyc < 128) begin
      busy_h[cyc] = busy;
      outs_h[cyc] = {bus.out_valid, bus.out_cp, bus.out_sop, bus.out_eop, bus.out_ch,
                     bus.ch_grant, bus.ch_rd_en, busy, underrun, overrun};
    end
    if (bus.out_valid) valid_n++;
    if (bus.out_cp) cp_n++;
    if (bus.ch_rd_en != '0) rd_n++;
    if (bus.ch_rd_en !== (bus.out_valid ? bus.ch_grant : 2'b00)) bad_rd++;
    if (bus.out_sop) begin
      sop_n++;
      sop_grant.push_back(bus.ch_grant);
      sop_ch.push_back(bus.out_ch);
      sop_cyc.push_back(cyc);
      cur_grant = bus.ch_grant;
    end else if (bus.out_valid && bus.ch_grant !== cur_grant) begin
      grant_chg++;
    end
    if (bus.out_eop) begin eop_n++; eop_cyc = cyc; end
    if (overrun) begin ov_n++; ov_cyc = cyc; end
    if (underrun) begin un_n++; un_cyc = cyc; end
    @(posedge clk_tx);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic trig(input logic lcp);
    tx_trigger = 1'b1;
    tx_lcp     = lcp;
    tick();
    tx_trigger = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; tx_trigger = 1'b0; tx_lcp = 1'b0;
    repeat (2) @(posedge clk_tx);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    clear_stats();
  endtask

  initial begin
    int gaps;
    bus.ch_mask  = 2'b11;
    bus.ch_ready = 2'b11;
    clear_stats();
    #2;
    check("reset_outs", {bus.out_valid, bus.out_cp, bus.out_sop, bus.out_eop, bus.out_ch,
                         bus.ch_grant, bus.ch_rd_en, busy, underrun, overrun}, 14'd0);
    check("reset_cnts", {underrun_cnt, overrun_cnt}, 32'd0);

    // 1: single long-CP burst
    do_reset();
    trig(1'b1);
    run_to(25);
    check("s1_sop_cyc", sop_cyc[0], 2);
    check("s1_grant", sop_grant[0], 2'b01);
    check("s1_cp_cycles", cp_n, 4);
    check("s1_eop_cyc", eop_cyc, 21);
    check("s1_rd_pulses", rd_n, 20);
    check("s1_valid_cycles", valid_n, 20);
    check("s1_busy21", busy_h[21], 1'b1);
    check("s1_busy22", busy_h[22], 1'b0);
    check("s1_rd_vs_grant", bad_rd, 0);

    // 2: back-to-back triggers every 18 cycles, normal CP
    do_reset();
    for (int c = 0; c < 65; c++) begin
      tx_trigger = (c == 0 || c == 18 || c == 36);
      tx_lcp     = 1'b0;
      tick();
    end
    tx_trigger = 1'b0;
    gaps = 0;
    for (int c = 1; c <= 57; c++) if (!busy_h[c]) gaps++;
    check("s2_bursts", sop_n, 3);
    check("s2_grant0", sop_grant[0], 2'b01);
    check("s2_grant1", sop_grant[1], 2'b10);
    check("s2_grant2", sop_grant[2], 2'b01);
    check("s2_sop1_cyc", sop_cyc[1], 21);
    check("s2_sop2_cyc", sop_cyc[2], 40);
    check("s2_overrun", ov_n, 0);
    check("s2_valid_cycles", valid_n, 54);
    check("s2_idle_gaps", gaps, 0);
    check("s2_busy58", busy_h[58], 1'b0);
    check("s2_grant_stable", grant_chg, 0);

    // 3: underrun, then a single ready requester
    do_reset();
    bus.ch_ready = 2'b00;
    trig(1'b0);
    run_to(6);
    check("s3_underrun_n", un_n, 1);
    check("s3_underrun_cyc", un_cyc, 1);
    check("s3_no_valid", valid_n, 0);
    check("s3_underrun_cnt", underrun_cnt, 1);
    check("s3_busy2", busy_h[2], 1'b0);
    bus.ch_ready = 2'b10;
    clear_stats();
    trig(1'b0);
    run_to(24);
    check("s3_grant", sop_grant[0], 2'b10);
    check("s3_out_ch", sop_ch[0], 3'd1);
    check("s3_no_underrun", un_n, 0);
    check("s3_underrun_cnt_kept", underrun_cnt, 1);
    bus.ch_ready = 2'b11;

    // 4: three triggers 3 cycles apart; the third is dropped and its lcp ignored
    do_reset();
    for (int c = 0; c < 50; c++) begin
      tx_trigger = (c == 0 || c == 3 || c == 6);
      tx_lcp     = (c == 3);
      tick();
    end
    tx_trigger = 1'b0;
    check("s4_overrun_n", ov_n, 1);
    check("s4_overrun_cyc", ov_cyc, 6);
    check("s4_overrun_cnt", overrun_cnt, 1);
    check("s4_bursts", sop_n, 2);
    check("s4_sop1_cyc", sop_cyc[1], 21);
    check("s4_cp_cycles", cp_n, 6);
    check("s4_eop_cyc", eop_cyc, 40);
    check("s4_busy41", busy_h[41], 1'b0);
    check("s4_grant1", sop_grant[1], 2'b10);

    // 5: enable dropped in the 5th BODY cycle with a pending trigger
    do_reset();
    for (int c = 0; c < 31; c++) begin
      tx_trigger = (c == 0 || c == 8);
      tx_lcp     = 1'b1;
      enable     = (c != 10);
      tick();
    end
    tx_trigger = 1'b0;
    enable     = 1'b1;
    gaps = 0;
    for (int c = 11; c <= 30; c++) if (busy_h[c]) gaps++;
    check("s5_outs_after_abort", outs_h[11], 14'd0);
    check("s5_no_eop", eop_n, 0);
    check("s5_valid_cycles", valid_n, 9);
    check("s5_pending_cleared", gaps, 0);
    clear_stats();
    trig(1'b0);
    run_to(24);
    check("s5_next_grant", sop_grant[0], 2'b10);
    check("s5_eop_after", eop_n, 1);

    // 6: only channel 1 enabled, pointer wraps each time
    do_reset();
    bus.ch_mask = 2'b10;
    for (int c = 0; c < 65; c++) begin
      tx_trigger = (c == 0 || c == 20 || c == 40);
      tx_lcp     = 1'b0;
      tick();
    end
    tx_trigger = 1'b0;
    check("s6_bursts", sop_n, 3);
    for (int i = 0; i < sop_grant.size(); i++) check("s6_grant", sop_grant[i], 2'b10);
    check("s6_no_underrun", un_n, 0);
    check("s6_eops", eop_n, 3);
    check("s6_rd_vs_grant", bad_rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
